// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, writeback value selection with load
// extension, GRF write port, W-stage forwarding source and retired-instruction counter.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_we,
  input  logic [4:0]  m_a3,
  input  logic [1:0]  m_wdsel,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_dm_rdata,
  input  logic [1:0]  m_addr_lo,
  input  logic [2:0]  m_ldtype,
  input  logic [31:0] m_md,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_wpc,
  output logic [4:0]  w_fwd_a3,
  output logic [31:0] w_fwd_wd,
  output logic [31:0] retired
);

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;
  localparam logic [1:0] WD_MD  = 2'd3;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  logic        valid_q;
  logic [31:0] pc_q;
  logic        we_q;
  logic [4:0]  a3_q;
  logic [1:0]  wdsel_q;
  logic [31:0] alu_q;
  logic [31:0] rdata_q;
  logic [1:0]  lo_q;
  logic [2:0]  ldtype_q;
  logic [31:0] md_q;
  logic        pend_q;
  logic [31:0] retired_q;

  logic        retire;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] wd;

  // Pipeline control: flush inserts a bubble and beats stall; stall holds every
  // field but clears pend_q so a held instruction writes/retires only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      we_q     <= 1'b0;
      a3_q     <= '0;
      wdsel_q  <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      lo_q     <= '0;
      ldtype_q <= '0;
      md_q     <= '0;
      pend_q   <= 1'b0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      we_q     <= 1'b0;
      a3_q     <= '0;
      wdsel_q  <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      lo_q     <= '0;
      ldtype_q <= '0;
      md_q     <= '0;
      pend_q   <= 1'b0;
    end else if (stall) begin
      pend_q   <= 1'b0;
    end else begin
      valid_q  <= m_valid;
      pc_q     <= m_pc;
      we_q     <= m_we;
      a3_q     <= m_a3;
      wdsel_q  <= m_wdsel;
      alu_q    <= m_alu;
      rdata_q  <= m_dm_rdata;
      lo_q     <= m_addr_lo;
      ldtype_q <= m_ldtype;
      md_q     <= m_md;
      pend_q   <= m_valid;
    end
  end

  assign retire = pend_q & valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    byte_sel = rdata_q[7:0];
    case (lo_q)
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
  end

  // Halfword alignment faults are trapped upstream, so only lo_q[1] matters here.
  assign half_sel = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_val = rdata_q;
    case (ldtype_q)
      LD_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_val = {24'd0, byte_sel};
      LD_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_val = {16'd0, half_sel};
      default: load_val = rdata_q;
    endcase
  end

  always_comb begin
    wd = alu_q;
    case (wdsel_q)
      WD_ALU:  wd = alu_q;
      WD_DM:   wd = load_val;
      WD_PC8:  wd = pc_q + 32'd8;
      WD_MD:   wd = md_q;
      default: wd = alu_q;
    endcase
  end

  assign grf_we   = retire & we_q & (a3_q != 5'd0);
  assign grf_a3   = a3_q;
  assign grf_wd   = wd;
  assign grf_wpc  = pc_q;
  assign w_fwd_a3 = grf_we ? a3_q : 5'd0;
  assign w_fwd_wd = wd;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for writeback selection/extension plus
// hand-written stall, flush and asynchronous-reset sequences.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [1:0]  m_wdsel;
  logic [31:0] m_alu;
  logic [31:0] m_dm_rdata;
  logic [1:0]  m_addr_lo;
  logic [2:0]  m_ldtype;
  logic [31:0] m_md;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_wpc;
  logic [4:0]  w_fwd_a3;
  logic [31:0] w_fwd_wd;
  logic [31:0] retired;

  int checks;
  int failures;

  wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_pc       (m_pc),
    .m_we       (m_we),
    .m_a3       (m_a3),
    .m_wdsel    (m_wdsel),
    .m_alu      (m_alu),
    .m_dm_rdata (m_dm_rdata),
    .m_addr_lo  (m_addr_lo),
    .m_ldtype   (m_ldtype),
    .m_md       (m_md),
    .grf_we     (grf_we),
    .grf_a3     (grf_a3),
    .grf_wd     (grf_wd),
    .grf_wpc    (grf_wpc),
    .w_fwd_a3   (w_fwd_a3),
    .w_fwd_wd   (w_fwd_wd),
    .retired    (retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  wdsel;
    logic [2:0]  ldtype;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] md;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        we;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    stall      = 1'b0;
    flush      = 1'b0;
    m_valid    = 1'b0;
    m_pc       = '0;
    m_we       = 1'b0;
    m_a3       = '0;
    m_wdsel    = '0;
    m_alu      = '0;
    m_dm_rdata = '0;
    m_addr_lo  = '0;
    m_ldtype   = '0;
    m_md       = '0;
  endtask

  task automatic drive_random();
    m_valid    = 1'b1;
    m_pc       = $urandom;
    m_we       = 1'b1;
    m_a3       = 5'($urandom_range(1, 31));
    m_wdsel    = 2'($urandom_range(0, 3));
    m_alu      = $urandom;
    m_dm_rdata = $urandom;
    m_addr_lo  = 2'($urandom_range(0, 3));
    m_ldtype   = 3'($urandom_range(0, 7));
    m_md       = $urandom;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] a3, input logic [31:0] alu);
    drive_idle();
    m_valid = 1'b1;
    m_we    = 1'b1;
    m_pc    = pc;
    m_a3    = a3;
    m_alu   = alu;
  endtask

  task automatic drive_vec(input vec_t v);
    drive_idle();
    m_valid    = 1'b1;
    m_we       = v.we;
    m_a3       = v.a3;
    m_pc       = v.pc;
    m_wdsel    = v.wdsel;
    m_alu      = v.alu;
    m_dm_rdata = v.rdata;
    m_addr_lo  = v.lo;
    m_ldtype   = v.ldtype;
    m_md       = v.md;
  endtask

  // scoreboard
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] wdsel, input logic [2:0] ldtype,
                              input logic [1:0] lo, input logic [31:0] rdata, input logic [31:0] alu,
                              input logic [31:0] md, input logic [31:0] pc, input logic [4:0] a3,
                              input logic we, input logic exp_we, input logic [31:0] exp_wd);
    vec_t v;
    v.name = name; v.wdsel = wdsel; v.ldtype = ldtype; v.lo = lo; v.rdata = rdata;
    v.alu = alu; v.md = md; v.pc = pc; v.a3 = a3; v.we = we;
    v.exp_we = exp_we; v.exp_wd = exp_wd;
    return v;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] exp_ret;
  logic [31:0] base;
  int          we_cnt;

  initial begin
    checks   = 0;
    failures = 0;
    exp_ret  = 0;

    vecs.push_back(mk("alu_write", 2'd0, 3'd0, 2'd0, 32'h0, 32'h00004e0c, 32'h0, 32'h00003000, 5'd5, 1'b1, 1'b1, 32'h00004e0c));
    vecs.push_back(mk("lb_lo3",    2'd1, 3'd1, 2'd3, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003004, 5'd6, 1'b1, 1'b1, 32'hFFFFFF80));
    vecs.push_back(mk("lbu_lo2",   2'd1, 3'd2, 2'd2, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003008, 5'd7, 1'b1, 1'b1, 32'h000000FF));
    vecs.push_back(mk("lh_lo0",    2'd1, 3'd3, 2'd0, 32'h80FF7F01, 32'h0, 32'h0, 32'h0000300c, 5'd8, 1'b1, 1'b1, 32'h00007F01));
    vecs.push_back(mk("lh_lo2",    2'd1, 3'd3, 2'd2, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003010, 5'd9, 1'b1, 1'b1, 32'hFFFF80FF));
    vecs.push_back(mk("lhu_lo2",   2'd1, 3'd4, 2'd2, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003014, 5'd10, 1'b1, 1'b1, 32'h000080FF));
    vecs.push_back(mk("lb_lo1",    2'd1, 3'd1, 2'd1, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003018, 5'd11, 1'b1, 1'b1, 32'h0000007F));
    vecs.push_back(mk("lbu_lo0",   2'd1, 3'd2, 2'd0, 32'h80FF7F81, 32'h0, 32'h0, 32'h0000301c, 5'd12, 1'b1, 1'b1, 32'h00000081));
    vecs.push_back(mk("lh_lo3",    2'd1, 3'd3, 2'd3, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003020, 5'd13, 1'b1, 1'b1, 32'hFFFF80FF));
    vecs.push_back(mk("lw",        2'd1, 3'd0, 2'd1, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003024, 5'd14, 1'b1, 1'b1, 32'h80FF7F01));
    vecs.push_back(mk("ld_type6",  2'd1, 3'd6, 2'd3, 32'h80FF7F01, 32'h0, 32'h0, 32'h00003028, 5'd15, 1'b1, 1'b1, 32'h80FF7F01));
    vecs.push_back(mk("zero_reg",  2'd0, 3'd0, 2'd0, 32'h0, 32'h00001234, 32'h0, 32'h0000302c, 5'd0, 1'b1, 1'b0, 32'h00001234));
    vecs.push_back(mk("jal_wrap",  2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd31, 1'b1, 1'b1, 32'h00000004));
    vecs.push_back(mk("mfhi",      2'd3, 3'd0, 2'd0, 32'h0, 32'h11111111, 32'hDEADBEEF, 32'h00003030, 5'd2, 1'b1, 1'b1, 32'hDEADBEEF));
    vecs.push_back(mk("no_we",     2'd0, 3'd0, 2'd0, 32'h0, 32'h00000077, 32'h0, 32'h00003034, 5'd7, 1'b0, 1'b0, 32'h00000077));

    // reset held with random inputs and a running clock
    reset = 1'b0;
    drive_idle();
    drive_random();
    repeat (4) begin
      @(posedge clk);
      #1;
      drive_random();
    end
    check32("rst_grf_we", grf_we, 0);
    check32("rst_retired", retired, 0);
    check32("rst_grf_wd", grf_wd, 0);
    check32("rst_fwd_a3", w_fwd_a3, 0);
    check32("rst_grf_wpc", grf_wpc, 0);
    drive_idle();
    reset = 1'b1;
    step();
    check32("post_rst_we", grf_we, 0);
    check32("post_rst_retired", retired, 0);

    // back-to-back vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      exp_q.push_back(vecs[i].exp_wd);
      step();
      check32({vecs[i].name, "_we"}, grf_we, vecs[i].exp_we);
      check32({vecs[i].name, "_wd"}, grf_wd, exp_q.pop_front());
      check32({vecs[i].name, "_fwd_wd"}, w_fwd_wd, vecs[i].exp_wd);
      check32({vecs[i].name, "_a3"}, grf_a3, vecs[i].a3);
      check32({vecs[i].name, "_fwd_a3"}, w_fwd_a3, vecs[i].exp_we ? vecs[i].a3 : 5'd0);
      check32({vecs[i].name, "_wpc"}, grf_wpc, vecs[i].pc);
      check32({vecs[i].name, "_retired"}, retired, exp_ret);
      exp_ret = exp_ret + 1;
    end
    drive_idle();
    step();
    check32("tbl_end_we", grf_we, 0);
    check32("tbl_end_retired", retired, exp_ret);

    // stall for three cycles: one write, one retire
    base = exp_ret;
    drive_instr(32'h00004000, 5'd9, 32'h00000055);
    step();
    we_cnt = grf_we ? 1 : 0;
    check32("stall_first_we", grf_we, 1);
    stall = 1'b1;
    m_a3  = 5'd3;
    m_alu = 32'h000000AA;
    repeat (3) begin
      step();
      if (grf_we) we_cnt++;
      check32("stall_hold_a3", grf_a3, 9);
      check32("stall_hold_wd", grf_wd, 32'h00000055);
    end
    drive_idle();
    step();
    check32("stall_we_count", we_cnt, 1);
    check32("stall_retired", retired, base + 1);
    exp_ret = base + 1;

    // flush together with stall inserts a bubble
    drive_instr(32'h00005000, 5'd4, 32'h00000099);
    flush = 1'b1;
    stall = 1'b1;
    step();
    check32("flush_stall_we", grf_we, 0);
    check32("flush_stall_fwd", w_fwd_a3, 0);
    drive_idle();
    step();
    check32("flush_stall_retired", retired, exp_ret);

    // asynchronous reset while a write is pending
    drive_instr(32'h00006000, 5'd12, 32'h00000abc);
    step();
    check32("pre_arst_we", grf_we, 1);
    #2 reset = 1'b0;
    #1;
    check32("arst_we", grf_we, 0);
    check32("arst_retired", retired, 0);
    check32("arst_a3", grf_a3, 0);
    drive_idle();
    step();
    reset = 1'b1;
    step();
    check32("arst_release_we", grf_we, 0);
    step();
    check32("arst_release_retired", retired, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage MIPS pipeline: the writer side of the general register file. It latches the MEM-stage result bundle into the MEM/WB pipeline register, selects and sign/zero-extends the writeback value, and drives the GRF write port (write enable, destination, data, PC). It also exposes the same values as the W-stage forwarding source and keeps a retired-instruction counter.

## Interface
- No parameters. Datapath is fixed at 32 bits and register indices at 5 bits.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. When 0, all state clears immediately.
- `stall` input 1: hold the MEM/WB register for this edge.
- `flush` input 1: load a bubble into the MEM/WB register for this edge.
- `m_valid` input 1: the MEM stage holds a real instruction.
- `m_pc` input 32: PC of the MEM-stage instruction.
- `m_we` input 1: the instruction writes a GPR.
- `m_a3` input 5: destination register index.
- `m_wdsel` input 2: writeback source. 0 = ALU, 1 = load data, 2 = PC+8, 3 = HI/LO move.
- `m_alu` input 32: ALU result.
- `m_dm_rdata` input 32: raw data-memory word.
- `m_addr_lo` input 2: low two bits of the memory address.
- `m_ldtype` input 3: load width. 0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu; 5–7 are treated as lw.
- `m_md` input 32: HI/LO value for mfhi/mflo.
- `grf_we` output 1: GRF write enable.
- `grf_a3` output 5: GRF write index.
- `grf_wd` output 32: GRF write data.
- `grf_wpc` output 32: PC of the instruction being written, used for the trace.
- `w_fwd_a3` output 5: forwarding destination. Equals `grf_a3` when `grf_we` is 1, otherwise 0.
- `w_fwd_wd` output 32: forwarding data. Equals `grf_wd`.
- `retired` output 32: count of instructions retired since reset.

## Operation
- MEM/WB register fields: `valid_q`, `pc_q`, `we_q`, `a3_q`, `wdsel_q`, `alu_q`, `rdata_q`, `lo_q`, `ldtype_q`, `md_q`, plus a one-shot flag `pend_q`.
- Priority at each rising edge: reset > flush > stall > load.
  - Flush: `valid_q`=0, `we_q`=0, `pend_q`=0. Other fields don't-care; implement them as cleared.
  - Stall: all fields hold; `pend_q`=0.
  - Load: all fields take the `m_*` values; `pend_q`=`m_valid`.
- Write enable: `grf_we` = `pend_q` & `valid_q` & `we_q` & (`a3_q` != 0). Combinational from registers only.
  - An instruction held by `stall` writes exactly once, in its first WB cycle.
- `grf_a3` = `a3_q`; `grf_wpc` = `pc_q`.
- Write data selection:
  - `wdsel_q`=0: `alu_q`.
  - `wdsel_q`=2: `pc_q`+8, wrapping modulo 2^32.
  - `wdsel_q`=3: `md_q`.
  - `wdsel_q`=1: load extension.
- Load extension:
  - Byte select: byte = `rdata_q[8*lo_q+7 : 8*lo_q]`.
  - Halfword select: `lo_q[1]` picks the upper (1) or lower (0) half. `lo_q[0]` is ignored; the misaligned exception is raised upstream.
  - lb and lh sign-extend. lbu and lhu zero-extend. lw (and types 5–7) passes the word unchanged.
- `retired` increments by 1 on each edge where `pend_q` & `valid_q` is 1, whether or not the instruction writes a GPR. It wraps from 0xFFFFFFFF to 0.
- Bubbles never write and never count.

## Timing
- Latency: MEM inputs sampled at edge N appear on the `grf_*` outputs after edge N.
  - The GRF commits them at edge N+1, so writeback is one cycle after the MEM/WB edge.
- `grf_wd` is combinational from MEM/WB registers. No input-to-output combinational path exists.
- Reset values, driven asynchronously while `reset`=0: all MEM/WB fields 0, `pend_q`=0, `grf_we`=0, `grf_a3`=0, `grf_wpc`=0, `retired`=0, `w_fwd_a3`=0.
  - `grf_wd` = 0, since `wdsel_q`=0 and `alu_q`=0.
- Reset asserted mid-instruction drops that write; no write is issued after release until a new load.
- `flush` and `stall` asserted together: flush wins and a bubble enters.
- Back-to-back loads with no stall: one write per cycle, in order.

## Test plan
- Reset: hold `reset`=0 with random `m_*` and toggling `clk` -> `grf_we`=0 and `retired`=0. Release `reset`; 1 cycle later `grf_we` is still 0, since no instruction has loaded yet.
- ALU write: `m_valid`=1, `m_we`=1, `m_a3`=5, `m_wdsel`=0, `m_alu`=0x00004e0c, `m_pc`=0x00003000 -> next cycle `grf_we`=1, `grf_a3`=5, `grf_wd`=0x00004e0c, `grf_wpc`=0x00003000, `retired`=1 after the following edge.
- Load extension: `m_dm_rdata`=0x80FF7F01, `m_wdsel`=1:
  - lb, `lo`=3 -> 0xFFFFFF80.
  - lbu, `lo`=2 -> 0x000000FF.
  - lh, `lo`=0 -> 0x00007F01.
  - lh, `lo`=2 -> 0xFFFF80FF.
  - lhu, `lo`=2 -> 0x000080FF.
- $0 and PC+8: `m_a3`=0, `m_we`=1 -> `grf_we`=0 but `retired` increments. Jal with `m_pc`=0xFFFFFFFC, `m_wdsel`=2, `m_a3`=31 -> `grf_wd`=0x00000004.
- Stall: load an instruction, then hold `stall`=1 for 3 cycles -> `grf_we`=1 for exactly 1 cycle and `retired` increments by exactly 1.
- Flush with stall, and reset mid-operation:
  - `flush`=1 and `stall`=1 together -> `grf_we`=0 next cycle and `retired` unchanged.
  - Assert `reset` asynchronously while `grf_we`=1 -> `grf_we` falls before the next clock edge.
